mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single CPU memory port between the fetch stage (instruction reads) and the load/store stage (data reads and writes). It sequences each access as a request/acknowledge transaction toward memory, which may have a variable number of wait states. It returns read data in a register and drives per-requester stall signals that hold the pipeline until the access completes. It sits between the fetch and memory stages and the external memory bus.

## Interface
- No parameters. Addresses are 30-bit word addresses and data is 32-bit, fixed by `defines.v`.
- clk_i  in  1  core clock
- rst_n_i  in  1  reset, asynchronous assert, active-low; one clock, and everything resets asynchronously on it
- if_re_i  in  1  fetch read request; held stable while if_stall_o=1
- if_addr_i  in  30  fetch word address
- if_data_o  out  32  registered instruction word
- if_stall_o  out  1  fetch must hold
- d_re_i  in  1  data read request
- d_we_i  in  1  data write request; d_re_i and d_we_i are never both 1 (d_we_i wins if violated)
- d_addr_i  in  30  data word address
- d_wdata_i  in  32  write data
- d_be_i  in  4  byte enables; bit n selects byte lane [8n+7:8n]
- d_rdata_o  out  32  registered load data
- d_stall_o  out  1  load/store stage must hold
- mem_req_o  out  1  memory request, held until acked
- mem_we_o  out  1  write strobe
- mem_addr_o  out  30  memory word address
- mem_wdata_o  out  32  memory write data
- mem_be_o  out  4  byte enables; 4'hF on reads
- mem_ack_i  in  1  access done; read data valid this cycle
- mem_rdata_i  in  32  memory read data

## Operation
- States:
  - IDLE
  - GNT_I, GNT_D: waiting for ack
  - DONE_I, DONE_D: one-cycle completion
- IDLE with a pending request goes to GNT_x. The address, write data, byte enables and write strobe are latched into registered mem_* outputs, and mem_req_o=1 from the next cycle.
- Both requests pending in IDLE: round-robin on last_gnt (reset = fetch, so the first conflict goes to data). Grant the port not granted last; update last_gnt on each grant.
- GNT_x with mem_ack_i=1:
  - Read: capture mem_rdata_i into if_data_o or d_rdata_o.
  - Clear mem_req_o and mem_we_o.
  - Go to DONE_x.
- GNT_x with mem_ack_i=0: hold all mem_* outputs stable.
- DONE_x: go to IDLE unconditionally. New requests are not sampled in DONE, because the requester still presents the old request this cycle.
- Stall outputs:
  - if_stall_o = if_re_i & ~(state==DONE_I)
  - d_stall_o = (d_re_i|d_we_i) & ~(state==DONE_D)
- A write leaves d_rdata_o unchanged. A data register changes only on an acked read of its own port.
- mem_ack_i outside GNT_x is ignored.
- A requester that drops its request mid-transaction does not abort it. The access completes, read data is still captured, and DONE is still visited.
- Reset asserted at any time (including mid-transaction):
  - State → IDLE.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_data_o, d_rdata_o, last_gnt → 0.
  - The in-flight access is abandoned.
- Stall outputs stay combinational during reset: asserted if the matching request is high.

## Timing
- Request seen in IDLE at edge N:
  - mem_req_o=1 in cycle N+1.
  - Ack sampled at the first edge M≥N+1 with mem_ack_i=1.
  - DONE in cycle M+1, stall low and data register valid in that cycle.
  - IDLE at M+2.
- Zero-wait memory (ack in first req cycle): 3 cycles per access, stall high for 2 cycles.
- Back-to-back accesses: minimum 3-cycle spacing. mem_req_o is low for at least 2 cycles between transactions (DONE and IDLE).
- k wait states add k cycles.

## Structure
- Add the state encoding (3-bit, 5 states) and the `MEM_BE_ALL 4'hF constant to `defines.v`.
- Single flat module. The two-way round-robin pick is one flop plus a mux, and a sub-module is not warranted.

## Test plan
- Single fetch, zero-wait: if_re_i=1, if_addr_i=30'h10, ack with mem_rdata_i=32'hDEADBEEF on first req cycle.
  - Expect mem_req_o high 1 cycle with mem_addr_o=30'h10.
  - Expect if_stall_o high 2 cycles.
  - Expect if_data_o=32'hDEADBEEF when the stall drops.
- Write with 2 wait states: d_we_i=1, d_addr_i=30'h20, d_wdata_i=32'h12345678, d_be_i=4'b0011.
  - Expect mem_we_o/mem_be_o=4'b0011 held stable 3 cycles.
  - Expect d_stall_o high 4 cycles.
  - Expect d_rdata_o unchanged.
- Simultaneous requests after reset: if_re_i and d_re_i both held.
  - Grant order must be data, fetch, data, fetch…, with each DONE pulse releasing only its own stall.
- Reset mid-access: assert rst_n_i=0 one cycle into GNT_D with ack withheld.
  - Expect mem_req_o=0 immediately, without waiting for a clock.
  - Expect state IDLE after release, and the next request served normally.
- Request dropped: d_re_i deasserted during GNT_D.
  - Expect mem_req_o to stay high until ack, d_rdata_o updated, and d_stall_o low throughout after the drop.
- Spurious ack: mem_ack_i=1 in IDLE with no request.
  - Expect no state change and no output register change.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
// State encoding, byte-enable constant and the round-robin pick.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GNT_I  = 3'd1,
        ST_GNT_D  = 3'd2,
        ST_DONE_I = 3'd3,
        ST_DONE_D = 3'd4
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [3:0] MEM_BE_ALL = 4'hF;

    // Data wins when it is the only requester, or on a conflict when fetch went last.
    function automatic logic pick_data(
        input logic  i_pend,
        input logic  d_pend,
        input port_t last
    );
        return d_pend & (~i_pend | (last == PORT_I));
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with a
// round-robin grant, variable wait states and registered read data.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_re_i,
    input  logic [29:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stall_o,
    input  logic        d_re_i,
    input  logic        d_we_i,
    input  logic [29:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_be_i,
    output logic [31:0] d_rdata_o,
    output logic        d_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    state_t state;
    port_t  last_gnt;

    logic i_pend;
    logic d_pend;
    logic take_d;

    assign i_pend = if_re_i;
    assign d_pend = d_re_i | d_we_i;
    assign take_d = pick_data(i_pend, d_pend, last_gnt);

    assign if_stall_o = if_re_i & (state != ST_DONE_I);
    assign d_stall_o  = d_pend & (state != ST_DONE_D);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            last_gnt    <= PORT_I;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            if_data_o   <= '0;
            d_rdata_o   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (take_d) begin
                        state       <= ST_GNT_D;
                        last_gnt    <= PORT_D;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        mem_be_o    <= d_we_i ? d_be_i : MEM_BE_ALL;
                    end else if (i_pend) begin
                        state      <= ST_GNT_I;
                        last_gnt   <= PORT_I;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                        mem_be_o   <= MEM_BE_ALL;
                    end
                end
                ST_GNT_I: begin
                    if (mem_ack_i) begin
                        if_data_o <= mem_rdata_i;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state     <= ST_DONE_I;
                    end
                end
                ST_GNT_D: begin
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            d_rdata_o <= mem_rdata_i;
                        end
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state     <= ST_DONE_D;
                    end
                end
                // The requester still shows the finished request here.
                ST_DONE_I,
                ST_DONE_D: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed corner cases,
// then randomized fetch/data traffic against a memory model.
module tb_mem_port_arbiter;

    typedef struct {
        bit          we;
        logic [29:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } tx_t;

    localparam int NTX = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_re = 1'b0;
    logic [29:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_stall;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [29:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        r_ack = 1'b0;
    logic [31:0] r_rdata = '0;
    bit          auto_mode = 1'b0;
    bit          go = 1'b0;
    bit          idone = 1'b0;
    bit          ddone = 1'b0;

    int tests = 0;
    int fails = 0;

    assign mem_ack   = auto_mode ? r_ack : m_ack;
    assign mem_rdata = auto_mode ? r_rdata : m_rdata;

    mem_port_arbiter dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .if_re_i     (if_re),
        .if_addr_i   (if_addr),
        .if_data_o   (if_data),
        .if_stall_o  (if_stall),
        .d_re_i      (d_re),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_be_i      (d_be),
        .d_rdata_o   (d_rdata),
        .d_stall_o   (d_stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural memory: unwritten words read back a pattern of their address.
    logic [31:0] mm [int];

    function automatic logic [31:0] mrd(input logic [29:0] a);
        if (mm.exists(int'(a))) return mm[int'(a)];
        return {2'b00, a} ^ 32'hA5A5_0000;
    endfunction

    function automatic void mwr(input logic [29:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] v;
        v = mrd(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        mm[int'(a)] = v;
    endfunction

    // Directed single access with a hand-driven ack after `waits` request cycles.
    task automatic manual_access(
        input  bit          dport,
        input  bit          wr,
        input  logic [29:0] a,
        input  logic [31:0] wd,
        input  logic [3:0]  be,
        input  int          waits,
        input  logic [31:0] rd,
        output int          stall_n,
        output int          req_n,
        output bit          stable,
        output logic [29:0] seen_addr,
        output logic [3:0]  seen_be,
        output logic        seen_we
    );
        bit   seen;
        bit   fin;
        int   w;
        logic st;
        @(posedge clk);
        #2;
        if (dport) begin
            d_re = !wr; d_we = wr; d_addr = a; d_wdata = wd; d_be = be;
        end else begin
            if_re = 1'b1; if_addr = a;
        end
        stall_n = 0; req_n = 0; stable = 1'b1; seen = 1'b0; fin = 1'b0; w = waits;
        seen_addr = '0; seen_be = '0; seen_we = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            st = dport ? d_stall : if_stall;
            if (!st) begin
                fin = 1'b1;
                break;
            end
            stall_n++;
            if (mem_req) begin
                req_n++;
                if (!seen) begin
                    seen_addr = mem_addr; seen_be = mem_be; seen_we = mem_we;
                end else if (mem_addr !== seen_addr || mem_be !== seen_be || mem_we !== seen_we) begin
                    stable = 1'b0;
                end
                seen = 1'b1;
                if (w == 0) begin
                    m_ack = 1'b1; m_rdata = rd;
                end else begin
                    w--;
                end
            end
            @(posedge clk);
            #1;
            m_ack = 1'b0;
        end
        chk("access_completes", 32'(fin), 32'd1);
        @(posedge clk);
        #2;
        if_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
    endtask

    // Random-phase scoreboard state.
    tx_t         qi[$];
    tx_t         qd[$];
    logic [31:0] rqi[$];
    logic [31:0] rqd[$];
    logic [31:0] dlast = '0;
    bit          last_d = 1'b0;
    bit          prev_req = 1'b0;
    int          gap = 2;
    logic        ei = 1'b0;
    logic        ed = 1'b0;
    int          rw = 0;

    always @(posedge clk) begin
        ei <= if_re;
        ed <= d_re | d_we;
    end

    // Memory responder: random wait states, occasional stray acks while idle.
    always @(negedge clk) begin
        if (auto_mode) begin
            if (mem_req) begin
                if (rw == 0) begin
                    r_ack   = 1'b1;
                    r_rdata = mrd(mem_addr);
                end else begin
                    r_ack = 1'b0;
                    rw--;
                end
            end else begin
                r_ack   = ($urandom_range(0, 5) == 0);
                r_rdata = $urandom;
                rw      = $urandom_range(0, 3);
            end
        end
    end

    // Monitor: grant order, bus contents, spacing and returned data.
    always @(negedge clk) begin
        tx_t tx;
        bit  port;
        if (auto_mode) begin
            if (mem_req && !prev_req) begin
                chk("req_gap", 32'(gap >= 2), 32'd1);
                gap = 0;
                if (!ei && !ed) begin
                    chk("grant_without_request", 32'd1, 32'd0);
                end else begin
                    port   = (ei && ed) ? !last_d : ed;
                    last_d = port;
                    if ((port ? qd.size() : qi.size()) == 0) begin
                        chk("grant_queue_empty", 32'd1, 32'd0);
                    end else begin
                        tx = port ? qd.pop_front() : qi.pop_front();
                        chk(port ? "d_addr" : "i_addr", 32'(mem_addr), 32'(tx.addr));
                        chk("mem_we", 32'(mem_we), 32'(tx.we));
                        chk("mem_be", 32'(mem_be), 32'(tx.we ? tx.be : 4'hF));
                        if (tx.we) begin
                            chk("mem_wdata", mem_wdata, tx.wd);
                            mwr(tx.addr, tx.wd, tx.be);
                        end else if (port) begin
                            rqd.push_back(mrd(tx.addr));
                        end else begin
                            rqi.push_back(mrd(tx.addr));
                        end
                    end
                end
            end else if (!mem_req) begin
                gap++;
            end
            prev_req = mem_req;
            if (if_re && !if_stall) begin
                if (rqi.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
                else chk("if_data", if_data, rqi.pop_front());
            end
            if (d_re && !d_stall) begin
                if (rqd.size() == 0) chk("d_done_unexpected", 32'd1, 32'd0);
                else begin
                    dlast = rqd.pop_front();
                    chk("d_rdata", d_rdata, dlast);
                end
            end
            if (d_we && !d_stall) chk("d_rdata_after_write", d_rdata, dlast);
        end
    end

    initial begin : fetch_drv
        bit fin;
        tx_t t;
        wait (go);
        @(posedge clk);
        #2;
        for (int n = 0; n < NTX; n++) begin
            int idle;
            idle = (n == 0) ? 0 : $urandom_range(0, 2);
            if (idle > 0) begin
                if_re = 1'b0;
                repeat (idle) begin @(posedge clk); #2; end
            end
            t.we = 1'b0; t.addr = 30'($urandom_range(0, 7)); t.wd = '0; t.be = 4'hF;
            if_addr = t.addr;
            if_re   = 1'b1;
            qi.push_back(t);
            fin = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (!if_stall) begin fin = 1'b1; break; end
            end
            if (!fin) chk("fetch_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #2;
        end
        if_re = 1'b0;
        idone = 1'b1;
    end

    initial begin : data_drv
        bit fin;
        tx_t t;
        wait (go);
        @(posedge clk);
        #2;
        for (int n = 0; n < NTX; n++) begin
            int idle;
            idle = (n == 0) ? 0 : $urandom_range(0, 2);
            if (idle > 0) begin
                d_re = 1'b0; d_we = 1'b0;
                repeat (idle) begin @(posedge clk); #2; end
            end
            t.we   = (n == 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
            t.addr = 30'($urandom_range(0, 7));
            t.wd   = $urandom;
            t.be   = 4'($urandom_range(1, 15));
            d_addr = t.addr; d_wdata = t.wd; d_be = t.be;
            d_re   = !t.we;
            d_we   = t.we;
            qd.push_back(t);
            fin = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (!d_stall) begin fin = 1'b1; break; end
            end
            if (!fin) chk("data_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #2;
        end
        d_re = 1'b0; d_we = 1'b0;
        ddone = 1'b1;
    end

    initial begin : main
        int          sn;
        int          rn;
        bit          stb;
        logic [29:0] sa;
        logic [3:0]  sb;
        logic        sw;
        bit          both;

        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        m_ack = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        m_ack = 1'b0;
        @(negedge clk);
        chk("spur_mem_req", 32'(mem_req), 32'd0);
        chk("spur_if_data", if_data, 32'd0);
        chk("spur_d_rdata", d_rdata, 32'd0);
        chk("spur_stall", 32'({if_stall, d_stall}), 32'd0);

        manual_access(1'b0, 1'b0, 30'h10, '0, '0, 0, 32'hDEADBEEF, sn, rn, stb, sa, sb, sw);
        chk("f0_stall_cycles", 32'(sn), 32'd2);
        chk("f0_req_cycles", 32'(rn), 32'd1);
        chk("f0_addr", 32'(sa), 32'h10);
        chk("f0_be", 32'(sb), 32'hF);
        chk("f0_if_data", if_data, 32'hDEADBEEF);

        manual_access(1'b1, 1'b0, 30'h3, '0, '0, 0, 32'h1111_2222, sn, rn, stb, sa, sb, sw);
        chk("r0_stall_cycles", 32'(sn), 32'd2);
        chk("r0_d_rdata", d_rdata, 32'h1111_2222);
        chk("r0_if_data_kept", if_data, 32'hDEADBEEF);

        manual_access(1'b1, 1'b1, 30'h20, 32'h1234_5678, 4'b0011, 2, 32'hFFFF_FFFF,
                      sn, rn, stb, sa, sb, sw);
        chk("w2_stall_cycles", 32'(sn), 32'd4);
        chk("w2_req_cycles", 32'(rn), 32'd3);
        chk("w2_stable", 32'(stb), 32'd1);
        chk("w2_be", 32'(sb), 32'h3);
        chk("w2_we", 32'(sw), 32'd1);
        chk("w2_d_rdata_kept", d_rdata, 32'h1111_2222);

        @(posedge clk);
        #2;
        d_re = 1'b1; d_addr = 30'h5;
        @(negedge clk);
        @(negedge clk);
        chk("mid_req_before_rst", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_async", 32'(mem_req), 32'd0);
        chk("mid_rst_d_stall", 32'(d_stall), 32'd1);
        chk("mid_rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #2;
        d_re = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        manual_access(1'b1, 1'b0, 30'h6, '0, '0, 0, 32'h3333_4444, sn, rn, stb, sa, sb, sw);
        chk("post_rst_stall_cycles", 32'(sn), 32'd2);
        chk("post_rst_d_rdata", d_rdata, 32'h3333_4444);

        @(posedge clk);
        #2;
        d_re = 1'b1; d_addr = 30'h7;
        @(negedge clk);
        @(negedge clk);
        d_re = 1'b0;
        #1;
        chk("drop_req_held", 32'(mem_req), 32'd1);
        chk("drop_stall_low", 32'(d_stall), 32'd0);
        @(negedge clk);
        chk("drop_req_still", 32'(mem_req), 32'd1);
        m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        @(negedge clk);
        chk("drop_req_cleared", 32'(mem_req), 32'd0);
        chk("drop_d_rdata", d_rdata, 32'hCAFE_F00D);
        chk("drop_stall_done", 32'(d_stall), 32'd0);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        auto_mode = 1'b1;
        go = 1'b1;
        both = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (idone && ddone) begin both = 1'b1; break; end
        end
        chk("random_phase_done", 32'(both), 32'd1);
        repeat (4) @(negedge clk);
        chk("qi_drained", 32'(qi.size()), 32'd0);
        chk("qd_drained", 32'(qd.size()), 32'd0);
        chk("rqi_drained", 32'(rqi.size()), 32'd0);
        chk("rqd_drained", 32'(rqd.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
